branch_redirect: RTL

Branch resolution and fetch-redirect unit for the pipelined LEGv8 core. It sits between the execute and memory stages and drives the redirect side of the fetch interface (`PCSrc_F`, `PCBranch_F`) that the `fetch` stage consumes. It resolves CBZ and B instructions in execute and registers the decision into the memory stage. It asserts the redirect for exactly one cycle, generates pipeline flushes, and squashes wrong-path branches already in flight.

---
 rtl/branch_redirect.sv | 91 +++++++++
 1 files changed

// File: rtl/branch_redirect.sv
// Branch resolution and fetch-redirect unit: resolves CBZ/B in execute and drives a
// registered, single-cycle redirect plus pipeline flushes into fetch/decode.
module branch_redirect #(
    parameter int N  = 64,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          Valid_E,
    input  logic [N-1:0]  PC_E,
    input  logic [N-1:0]  SignImm_E,
    input  logic          Branch_E,
    input  logic          UncondBranch_E,
    input  logic          Zero_E,
    output logic          PCSrc_F,
    output logic [N-1:0]  PCBranch_F,
    output logic          Flush_D,
    output logic          Flush_E,
    output logic [CW-1:0] TakenCount,
    output logic [CW-1:0] SquashCount
);

    typedef enum logic {IDLE, REDIRECT} state_t;

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state;
    state_t        state_next;
    logic          squash;
    logic          take_e;
    logic          squash_event;
    logic [N-1:0]  target_e;
    logic [N-1:0]  target_m;
    logic [CW-1:0] taken_cnt;
    logic [CW-1:0] squash_cnt;

    assign target_e = PC_E + (SignImm_E << 2);

    // The E-stage instruction during a redirect cycle is wrong-path, so it can never be taken.
    always_comb begin
        squash       = (state == REDIRECT);
        take_e       = ~reset & Valid_E & ~squash & (UncondBranch_E | (Branch_E & Zero_E));
        squash_event = squash & Valid_E & (UncondBranch_E | Branch_E);
    end

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:     if (take_e) state_next = REDIRECT;
            REDIRECT: if (take_e) state_next = REDIRECT;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        PCSrc_F     = 1'b0;
        Flush_D     = 1'b0;
        Flush_E     = 1'b0;
        PCBranch_F  = target_m;
        TakenCount  = taken_cnt;
        SquashCount = squash_cnt;
        if (state == REDIRECT) begin
            PCSrc_F = 1'b1;
            Flush_D = 1'b1;
            Flush_E = 1'b1;
        end
    end

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            target_m   <= '0;
            taken_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            state <= state_next;
            if (take_e) begin
                target_m <= target_e;
            end
            if (take_e && (taken_cnt != CNT_MAX)) begin
                taken_cnt <= taken_cnt + CNT_ONE;
            end
            if (squash_event && (squash_cnt != CNT_MAX)) begin
                squash_cnt <= squash_cnt + CNT_ONE;
            end
        end
    end

endmodule
